// File: rtl/display_scanout.sv
// display_scanout: raster timing generator and frame-store read sequencer.
// Issues one linear read address per active pixel, then realigns the returned
// pixel with hsync/vsync/de/frame_start across the frame store read latency.
module display_scanout #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_ACTIVE     = 400,
  parameter int V_FRONT      = 12,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 35,
  parameter int READ_LATENCY = 3
) (
  input  logic        clock_in,
  input  logic        reset_n_in,
  input  logic        enable_in,
  output logic [17:0] pixel_read_address_out,
  input  logic [3:0]  pixel_read_data_in,
  output logic        display_hsync_out,
  output logic        display_vsync_out,
  output logic        display_data_enable_out,
  output logic [3:0]  display_pixel_out,
  output logic        frame_start_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST_C  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG_C  = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END_C  = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST_C  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG_C  = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END_C  = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [17:0]   ADDR_LAST = 18'(H_ACTIVE * V_ACTIVE - 1);

  // Control word bit positions inside the delay pipeline
  localparam int CTL_HS = 0;
  localparam int CTL_VS = 1;
  localparam int CTL_DE = 2;
  localparam int CTL_FS = 3;

  logic          run_q, run_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [17:0]   addr_q, addr_d;
  logic          raw_de_s;
  logic [3:0]    ctl_raw_s;
  logic [3:0]    ctl_q [1:READ_LATENCY];
  logic          pre_de_s;
  logic [3:0]    pixel_q;

  // Decode raw timing controls from the current raster position
  always_comb begin
    raw_de_s             = run_q && (h_q < H_ACT_C) && (v_q < V_ACT_C);
    ctl_raw_s            = 4'b0000;
    ctl_raw_s[CTL_HS]    = (h_q >= HS_BEG_C) && (h_q < HS_END_C);
    ctl_raw_s[CTL_VS]    = (v_q >= VS_BEG_C) && (v_q < VS_END_C);
    ctl_raw_s[CTL_DE]    = raw_de_s;
    ctl_raw_s[CTL_FS]    = raw_de_s && (h_q == {HW{1'b0}}) && (v_q == {VW{1'b0}});
  end

  // Next-state for raster counters and read address; the first enabled cycle only arms the engine
  always_comb begin
    run_d  = run_q;
    h_d    = h_q;
    v_d    = v_q;
    addr_d = addr_q;
    if (!enable_in) begin
      run_d  = 1'b0;
      h_d    = {HW{1'b0}};
      v_d    = {VW{1'b0}};
      addr_d = 18'd0;
    end else if (!run_q) begin
      run_d  = 1'b1;
      h_d    = {HW{1'b0}};
      v_d    = {VW{1'b0}};
      addr_d = 18'd0;
    end else begin
      if (h_q == H_LAST_C) begin
        h_d = {HW{1'b0}};
        if (v_q == V_LAST_C) begin
          v_d = {VW{1'b0}};
        end else begin
          v_d = v_q + VW'(1);
        end
      end else begin
        h_d = h_q + HW'(1);
        v_d = v_q;
      end
      // Address parks at 0 after the last pixel so the buffer swap window covers all of vblank
      if (raw_de_s) begin
        if (addr_q == ADDR_LAST) begin
          addr_d = 18'd0;
        end else begin
          addr_d = addr_q + 18'd1;
        end
      end else begin
        addr_d = addr_q;
      end
    end
  end

  // Raster and address state registers
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      run_q  <= 1'b0;
      h_q    <= {HW{1'b0}};
      v_q    <= {VW{1'b0}};
      addr_q <= 18'd0;
    end else begin
      run_q  <= run_d;
      h_q    <= h_d;
      v_q    <= v_d;
      addr_q <= addr_d;
    end
  end

  // The stage just before the output lines up with the returning read data
  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign pre_de_s = ctl_raw_s[CTL_DE];
    end else begin : g_latn
      assign pre_de_s = ctl_q[READ_LATENCY-1][CTL_DE];
    end
  endgenerate

  // Control delay line and pixel capture; last stage drives the pins directly
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int k = 1; k <= READ_LATENCY; k++) begin
        ctl_q[k] <= 4'b0000;
      end
      pixel_q <= 4'b0000;
    end else if (!enable_in) begin
      for (int k = 1; k <= READ_LATENCY; k++) begin
        ctl_q[k] <= 4'b0000;
      end
      pixel_q <= 4'b0000;
    end else begin
      ctl_q[1] <= ctl_raw_s;
      for (int k = 2; k <= READ_LATENCY; k++) begin
        ctl_q[k] <= ctl_q[k-1];
      end
      pixel_q <= pre_de_s ? pixel_read_data_in : 4'b0000;
    end
  end

  assign pixel_read_address_out  = addr_q;
  assign display_hsync_out       = ctl_q[READ_LATENCY][CTL_HS];
  assign display_vsync_out       = ctl_q[READ_LATENCY][CTL_VS];
  assign display_data_enable_out = ctl_q[READ_LATENCY][CTL_DE];
  assign frame_start_out         = ctl_q[READ_LATENCY][CTL_FS];
  assign display_pixel_out       = pixel_q;

endmodule

// File: tb/tb_display_scanout.sv
// Bench for display_scanout: one default-geometry instance checked against a
// hand-computed vector table, plus three reduced-geometry instances
// (latency 1, 3, 7) checked every cycle against an arithmetic raster model.
module tb_display_scanout;

  logic clk;
  logic rst_n;
  logic enable;
  int   p;          // cycles since the engine was armed; -1 while idle
  int   errors;
  int   checks;

  // Instance 0 = default geometry, 1..3 = small geometry 15x8 with latency 1/3/7
  localparam int         LAT  [4] = '{3, 1, 3, 7};
  localparam logic [3:0] MASK [4] = '{4'h0, 4'hF, 4'hF, 4'hF};
  localparam int SHT = 15;   // 8+2+3+2
  localparam int SVT = 8;    // 4+1+2+1
  localparam int SFR = SHT * SVT;

  logic [17:0] addr_w  [4];
  logic [3:0]  rdata_w [4];
  logic        hs_w    [4];
  logic        vs_w    [4];
  logic        de_w    [4];
  logic        fs_w    [4];
  logic [3:0]  pix_w   [4];
  logic [17:0] hist    [4][8];

  display_scanout #(.READ_LATENCY(3)) u_dut (
    .clock_in(clk), .reset_n_in(rst_n), .enable_in(enable),
    .pixel_read_address_out(addr_w[0]), .pixel_read_data_in(rdata_w[0]),
    .display_hsync_out(hs_w[0]), .display_vsync_out(vs_w[0]),
    .display_data_enable_out(de_w[0]), .display_pixel_out(pix_w[0]),
    .frame_start_out(fs_w[0]));

  display_scanout #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                    .READ_LATENCY(1)) u_s1 (
    .clock_in(clk), .reset_n_in(rst_n), .enable_in(enable),
    .pixel_read_address_out(addr_w[1]), .pixel_read_data_in(rdata_w[1]),
    .display_hsync_out(hs_w[1]), .display_vsync_out(vs_w[1]),
    .display_data_enable_out(de_w[1]), .display_pixel_out(pix_w[1]),
    .frame_start_out(fs_w[1]));

  display_scanout #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                    .READ_LATENCY(3)) u_s3 (
    .clock_in(clk), .reset_n_in(rst_n), .enable_in(enable),
    .pixel_read_address_out(addr_w[2]), .pixel_read_data_in(rdata_w[2]),
    .display_hsync_out(hs_w[2]), .display_vsync_out(vs_w[2]),
    .display_data_enable_out(de_w[2]), .display_pixel_out(pix_w[2]),
    .frame_start_out(fs_w[2]));

  display_scanout #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                    .READ_LATENCY(7)) u_s7 (
    .clock_in(clk), .reset_n_in(rst_n), .enable_in(enable),
    .pixel_read_address_out(addr_w[3]), .pixel_read_data_in(rdata_w[3]),
    .display_hsync_out(hs_w[3]), .display_vsync_out(vs_w[3]),
    .display_data_enable_out(de_w[3]), .display_pixel_out(pix_w[3]),
    .frame_start_out(fs_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Position counter: 0 on the first cycle after enable is sampled high
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      p <= -1;
    else if (enable) p <= p + 1;
    else             p <= -1;
  end

  // Frame store model: data sampled by the DUT exactly LAT edges after its address was launched
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int k = 7; k > 0; k--) hist[i][k] <= hist[i][k-1];
      hist[i][0] <= addr_w[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (LAT[i] == 1) rdata_w[i] = addr_w[i][3:0] ^ MASK[i];
      else             rdata_w[i] = hist[i][(LAT[i] > 1) ? (LAT[i] - 2) : 0][3:0] ^ MASK[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s p=%0d got=%0h expected=%0h", name, p, act, exp);
    end
  endtask

  // Small-geometry address at raster position q (8 active, 4 lines, 15x8 total)
  function automatic int m_addr(input int pos);
    int q, h, v;
    q = pos % SFR;
    h = q % SHT;
    v = q / SHT;
    if (v >= 4) return 0;
    if (h < 8)  return v * 8 + h;
    if (v == 3) return 0;
    return v * 8 + 8;
  endfunction

  task automatic check_small();
    for (int i = 1; i < 4; i++) begin
      int l, q, h, v, a;
      logic e_de, e_hs, e_vs, e_fs;
      logic [3:0] e_px;
      l = LAT[i];
      e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_fs = 1'b0; e_px = 4'd0;
      a = (p < 0) ? 0 : m_addr(p);
      chk($sformatf("s%0d_addr", l), 32'(addr_w[i]), 32'(a));
      if (p >= l) begin
        q = (p - l) % SFR;
        h = q % SHT;
        v = q / SHT;
        e_de = (h < 8) && (v < 4);
        e_hs = (h >= 10) && (h < 13);
        e_vs = (v >= 5) && (v < 7);
        e_fs = (q == 0);
        a = m_addr(q);
        e_px = e_de ? (a[3:0] ^ 4'hF) : 4'd0;
      end
      chk($sformatf("s%0d_de", l), 32'(de_w[i]), 32'(e_de));
      chk($sformatf("s%0d_hs", l), 32'(hs_w[i]), 32'(e_hs));
      chk($sformatf("s%0d_vs", l), 32'(vs_w[i]), 32'(e_vs));
      chk($sformatf("s%0d_fs", l), 32'(fs_w[i]), 32'(e_fs));
      chk($sformatf("s%0d_pix", l), 32'(pix_w[i]), 32'(e_px));
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_small();
  endtask

  task automatic wait_p(input int target);
    int budget;
    budget = 3000;
    while (p < target && budget > 0) begin
      step();
      budget--;
    end
    if (p != target) begin
      errors++;
      $display("FAIL wait_p timeout got=%0d expected=%0d", p, target);
    end
  endtask

  task automatic check_dflt(input string tag, input logic [17:0] a, input logic de,
                            input logic hs, input logic vs, input logic fs, input logic [3:0] px);
    chk({tag, "_addr"}, 32'(addr_w[0]), 32'(a));
    chk({tag, "_de"},   32'(de_w[0]),   32'(de));
    chk({tag, "_hs"},   32'(hs_w[0]),   32'(hs));
    chk({tag, "_vs"},   32'(vs_w[0]),   32'(vs));
    chk({tag, "_fs"},   32'(fs_w[0]),   32'(fs));
    chk({tag, "_pix"},  32'(pix_w[0]),  32'(px));
  endtask

  typedef struct {
    int          p;
    logic [17:0] addr;
    logic        de, hs, vs, fs;
    logic [3:0]  pix;
  } vec_t;

  vec_t tbl [17];

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    enable = 1'b0;

    // First line of the default instance (latency 3, pixel = addr[3:0])
    tbl[0]  = '{0,   18'd0,   1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{2,   18'd2,   1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[2]  = '{3,   18'd3,   1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
    tbl[3]  = '{4,   18'd4,   1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
    tbl[4]  = '{20,  18'd20,  1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
    tbl[5]  = '{639, 18'd639, 1'b1, 1'b0, 1'b0, 1'b0, 4'd12};
    tbl[6]  = '{640, 18'd640, 1'b1, 1'b0, 1'b0, 1'b0, 4'd13};
    tbl[7]  = '{642, 18'd640, 1'b1, 1'b0, 1'b0, 1'b0, 4'd15};
    tbl[8]  = '{643, 18'd640, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[9]  = '{658, 18'd640, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[10] = '{659, 18'd640, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[11] = '{754, 18'd640, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[12] = '{755, 18'd640, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[13] = '{800, 18'd640, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[14] = '{801, 18'd641, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[15] = '{803, 18'd643, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[16] = '{804, 18'd644, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1};

    // Reset held, then idle with enable low
    repeat (5) step();
    check_dflt("reset", 18'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    #1 rst_n = 1'b1;
    repeat (100) step();
    check_dflt("idle", 18'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Enable and walk the vector table
    #1 enable = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wait_p(tbl[i].p);
      check_dflt($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].de, tbl[i].hs,
                 tbl[i].vs, tbl[i].fs, tbl[i].pix);
    end

    // Abort mid-line (default at h=195 v=1, small at h=5 v=2)
    wait_p(995);
    check_dflt("pre_abort", 18'd835, 1'b1, 1'b0, 1'b0, 1'b0, 4'((18'd832) & 18'hF));
    #1 enable = 1'b0;
    step();
    check_dflt("abort", 18'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (49) step();
    #1 enable = 1'b1;
    wait_p(0);
    check_dflt("rearm0", 18'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    wait_p(3);
    check_dflt("rearm3", 18'd3, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    wait_p(4);
    check_dflt("rearm4", 18'd4, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);

    // Asynchronous reset mid active line
    wait_p(125);
    check_dflt("pre_rst", 18'd125, 1'b1, 1'b0, 1'b0, 1'b0, 4'd10);
    #2 rst_n = 1'b0;
    #1;
    check_dflt("async_rst", 18'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check_small();
    repeat (3) step();
    #1 rst_n = 1'b1;
    wait_p(0);
    check_dflt("post_rst0", 18'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    wait_p(3);
    check_dflt("post_rst3", 18'd3, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    wait_p(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
